// File: rtl/m_mem_map_pkg.sv
// m_mem_map_pkg
// Shared memory-map definitions for the CPU memory decoders (read and write side).
//   region_t   : region encoding driven on the decoders' sel outputs
//   *_LO/*_HI  : inclusive 12-bit address bounds of each region
//   rd_state_t : state encoding of the read-return FSM
//   strobe_of  : one-hot {instr, mmr, stack} strobe pattern for a region
package m_mem_map_pkg;

    typedef enum logic [1:0] {
        REG_INSTR = 2'd0,
        REG_MMR   = 2'd1,
        REG_STACK = 2'd2
    } region_t;

    localparam logic [11:0] INSTR_LO = 12'h000;
    localparam logic [11:0] INSTR_HI = 12'h400;
    localparam logic [11:0] MMR_LO   = 12'h401;
    localparam logic [11:0] MMR_HI   = 12'h44B;
    localparam logic [11:0] STACK_LO = 12'h44C;
    localparam logic [11:0] STACK_HI = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } rd_state_t;

    // One-hot strobe vector ordered {instr, mmr, stack}.
    function automatic logic [2:0] strobe_of(input region_t r);
        logic [2:0] s;
        case (r)
            REG_INSTR: s = 3'b100;
            REG_MMR:   s = 3'b010;
            REG_STACK: s = 3'b001;
            default:   s = 3'b000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/m_region_decode.sv
// m_region_decode
// Combinational address-to-region decoder shared by the read and write paths.
//   addr_i   in  12  CPU address
//   region_o out  2  decoded region (every address maps to exactly one region)
module m_region_decode
    import m_mem_map_pkg::*;
(
    input  logic [11:0] addr_i,
    output region_t     region_o
);

    // Inclusive range compare; the instruction floor (0) and stack ceiling
    // (0xFFF) are implied by the 12-bit address width.
    always_comb begin
        region_o = REG_STACK;
        if (addr_i <= INSTR_HI) begin
            region_o = REG_INSTR;
        end else if ((addr_i >= MMR_LO) && (addr_i <= MMR_HI)) begin
            region_o = REG_MMR;
        end else begin
            region_o = REG_STACK;
        end
    end

endmodule

// File: rtl/m_read_return.sv
// m_read_return
// Read-side memory front end: accepts a CPU read, strobes the decoded region
// once, waits that region's fixed latency, and returns the captured word with a
// one-cycle valid pulse.
//   clk, rst_n                      clock, async active-low reset
//   MEMREAD, addr                   read request (sampled while ready=1)
//   ready                           idle, request accepted this cycle
//   rd_addr, sel                    latched address/region, held until next accept
//   rd_instr, rd_mmr, rd_stack      one-cycle region read strobes
//   instr_data, mmr_data, stack_data region read data buses
//   data_out, data_valid            returned word and its one-cycle valid pulse
module m_read_return
    import m_mem_map_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int INSTR_LAT = 1,
    parameter int MMR_LAT   = 1,
    parameter int STACK_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MEMREAD,
    input  logic [11:0]       addr,
    output logic              ready,
    output logic [11:0]       rd_addr,
    output logic [1:0]        sel,
    output logic              rd_instr,
    output logic              rd_mmr,
    output logic              rd_stack,
    input  logic [DATA_W-1:0] instr_data,
    input  logic [DATA_W-1:0] mmr_data,
    input  logic [DATA_W-1:0] stack_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    // The wait counter is 3 bits, so each latency must lie in 1..7.
    if ((INSTR_LAT < 1) || (INSTR_LAT > 7)) begin : g_bad_instr_lat
        $error("m_read_return: INSTR_LAT must be in 1..7");
    end
    if ((MMR_LAT < 1) || (MMR_LAT > 7)) begin : g_bad_mmr_lat
        $error("m_read_return: MMR_LAT must be in 1..7");
    end
    if ((STACK_LAT < 1) || (STACK_LAT > 7)) begin : g_bad_stack_lat
        $error("m_read_return: STACK_LAT must be in 1..7");
    end

    localparam logic [2:0] INSTR_LAT_C = 3'(INSTR_LAT);
    localparam logic [2:0] MMR_LAT_C   = 3'(MMR_LAT);
    localparam logic [2:0] STACK_LAT_C = 3'(STACK_LAT);

    function automatic logic [2:0] lat_of(input region_t r);
        logic [2:0] l;
        case (r)
            REG_INSTR: l = INSTR_LAT_C;
            REG_MMR:   l = MMR_LAT_C;
            REG_STACK: l = STACK_LAT_C;
            default:   l = INSTR_LAT_C;
        endcase
        return l;
    endfunction

    rd_state_t         state_q;
    logic [2:0]        cnt_q;
    logic              ready_q;
    logic [11:0]       rd_addr_q;
    region_t           sel_q;
    logic              rd_instr_q;
    logic              rd_mmr_q;
    logic              rd_stack_q;
    logic [DATA_W-1:0] data_out_q;
    logic              data_valid_q;

    region_t           region_s;
    logic [DATA_W-1:0] sel_data_s;

    m_region_decode u_region_decode (
        .addr_i   (addr),
        .region_o (region_s)
    );

    // Only the latched region's bus is looked at; the others are don't-care.
    always_comb begin
        sel_data_s = {DATA_W{1'b0}};
        case (sel_q)
            REG_INSTR: sel_data_s = instr_data;
            REG_MMR:   sel_data_s = mmr_data;
            REG_STACK: sel_data_s = stack_data;
            default:   sel_data_s = {DATA_W{1'b0}};
        endcase
    end

    // Read FSM with wait counter, capture register and registered outputs.
    // ready_q stays low while rst_n is asserted and rises on the first edge
    // after release, so a request can never be accepted in that first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            ready_q      <= 1'b0;
            rd_addr_q    <= 12'h000;
            sel_q        <= REG_INSTR;
            rd_instr_q   <= 1'b0;
            rd_mmr_q     <= 1'b0;
            rd_stack_q   <= 1'b0;
            data_out_q   <= {DATA_W{1'b0}};
            data_valid_q <= 1'b0;
        end else begin
            // Strobes and valid are single-cycle pulses by default.
            rd_instr_q   <= 1'b0;
            rd_mmr_q     <= 1'b0;
            rd_stack_q   <= 1'b0;
            data_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (MEMREAD) begin
                        ready_q    <= 1'b0;
                        rd_addr_q  <= addr;
                        sel_q      <= region_s;
                        cnt_q      <= lat_of(region_s);
                        {rd_instr_q, rd_mmr_q, rd_stack_q} <= strobe_of(region_s);
                        state_q    <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        data_out_q   <= sel_data_s;
                        data_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    cnt_q   <= 3'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign rd_addr    = rd_addr_q;
    assign sel        = sel_q;
    assign rd_instr   = rd_instr_q;
    assign rd_mmr     = rd_mmr_q;
    assign rd_stack   = rd_stack_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_m_read_return.sv
// tb_m_read_return
// Directed self-checking bench for m_read_return (default parameters:
// INSTR_LAT=1, MMR_LAT=1, STACK_LAT=2). Inputs change and outputs are sampled
// on the falling clock edge.
module tb_m_read_return;

    logic        clk;
    logic        rst_n;
    logic        MEMREAD;
    logic [11:0] addr;
    logic        ready;
    logic [11:0] rd_addr;
    logic [1:0]  sel;
    logic        rd_instr;
    logic        rd_mmr;
    logic        rd_stack;
    logic [15:0] instr_data;
    logic [15:0] mmr_data;
    logic [15:0] stack_data;
    logic [15:0] data_out;
    logic        data_valid;

    int n_chk  = 0;
    int n_fail = 0;

    m_read_return #(
        .DATA_W    (16),
        .INSTR_LAT (1),
        .MMR_LAT   (1),
        .STACK_LAT (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MEMREAD    (MEMREAD),
        .addr       (addr),
        .ready      (ready),
        .rd_addr    (rd_addr),
        .sel        (sel),
        .rd_instr   (rd_instr),
        .rd_mmr     (rd_mmr),
        .rd_stack   (rd_stack),
        .instr_data (instr_data),
        .mmr_data   (mmr_data),
        .stack_data (stack_data),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One read transaction, entered at the falling edge of the accept cycle.
    // With hold=1 MEMREAD stays high and addr moves to a2 right after accept,
    // so the next accept happens in the cycle after RESP.
    task automatic rd_txn(input logic [11:0] a, input logic [1:0] es, input logic [15:0] ed,
                          input int lat, input bit hold, input logic [11:0] a2);
        int         cyc;
        bit         seen;
        logic [2:0] exp_strb;
        exp_strb = (es == 2'd0) ? 3'b100 : ((es == 2'd1) ? 3'b010 : 3'b001);
        chk("ready_at_accept", {31'd0, ready}, 32'd1);
        MEMREAD = 1'b1;
        addr    = a;
        @(negedge clk);
        if (hold) begin
            addr = a2;
        end else begin
            MEMREAD = 1'b0;
            addr    = ~a;
        end
        chk("ready_issue", {31'd0, ready}, 32'd0);
        chk("sel", {30'd0, sel}, {30'd0, es});
        chk("rd_addr_issue", {20'd0, rd_addr}, {20'd0, a});
        chk("strobe_issue", {29'd0, rd_instr, rd_mmr, rd_stack}, {29'd0, exp_strb});
        chk("dv_issue", {31'd0, data_valid}, 32'd0);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && (cyc < 12)) begin
            @(negedge clk);
            cyc++;
            if (data_valid) begin
                seen = 1'b1;
            end else begin
                chk("strobe_wait", {29'd0, rd_instr, rd_mmr, rd_stack}, 32'd0);
                chk("rd_addr_wait", {20'd0, rd_addr}, {20'd0, a});
                chk("ready_wait", {31'd0, ready}, 32'd0);
            end
        end
        chk("dv_latency", cyc, 2 + lat);
        chk("data_out", {16'd0, data_out}, {16'd0, ed});
        chk("ready_resp", {31'd0, ready}, 32'd0);
        chk("strobe_resp", {29'd0, rd_instr, rd_mmr, rd_stack}, 32'd0);
        @(negedge clk);
        chk("ready_after", {31'd0, ready}, 32'd1);
        chk("dv_after", {31'd0, data_valid}, 32'd0);
        chk("data_hold", {16'd0, data_out}, {16'd0, ed});
        chk("sel_hold", {30'd0, sel}, {30'd0, es});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n      = 1'b0;
        MEMREAD    = 1'b0;
        addr       = 12'h000;
        instr_data = 16'h0000;
        mmr_data   = 16'h0000;
        stack_data = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rd_addr", {20'd0, rd_addr}, 32'd0);
        chk("rst_sel", {30'd0, sel}, 32'd0);
        chk("rst_strobes", {29'd0, rd_instr, rd_mmr, rd_stack}, 32'd0);
        chk("rst_data_out", {16'd0, data_out}, 32'd0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        rst_n   = 1'b1;
        MEMREAD = 1'b1;
        addr    = 12'h222;
        chk("ready_at_release", {31'd0, ready}, 32'd0);
        @(negedge clk);
        chk("ready_first_edge", {31'd0, ready}, 32'd1);
        chk("no_accept_at_release", {29'd0, rd_instr, rd_mmr, rd_stack}, 32'd0);
        MEMREAD = 1'b0;

        // Basic instruction read
        instr_data = 16'hBEEF;
        rd_txn(12'h123, 2'd0, 16'hBEEF, 1, 1'b0, 12'h000);

        // Boundary sweep
        instr_data = 16'h1111;
        mmr_data   = 16'h2222;
        stack_data = 16'h3333;
        rd_txn(12'h400, 2'd0, 16'h1111, 1, 1'b0, 12'h000);
        rd_txn(12'h401, 2'd1, 16'h2222, 1, 1'b0, 12'h000);
        rd_txn(12'h44B, 2'd1, 16'h2222, 1, 1'b0, 12'h000);
        rd_txn(12'h44C, 2'd2, 16'h3333, 2, 1'b0, 12'h000);
        rd_txn(12'hFFF, 2'd2, 16'h3333, 2, 1'b0, 12'h000);

        // Stack read with MEMREAD held and addr toggled during WAIT, then the
        // held request is accepted after RESP as a fresh instruction read.
        stack_data = 16'h1234;
        instr_data = 16'h0F0F;
        rd_txn(12'h800, 2'd2, 16'h1234, 2, 1'b1, 12'h010);
        rd_txn(12'h010, 2'd0, 16'h0F0F, 1, 1'b0, 12'h000);

        // Back-to-back reads with MEMREAD held continuously
        stack_data = 16'h5A5A;
        instr_data = 16'hC3C3;
        rd_txn(12'h450, 2'd2, 16'h5A5A, 2, 1'b1, 12'h002);
        rd_txn(12'h002, 2'd0, 16'hC3C3, 1, 1'b0, 12'h000);

        // Reset asserted during WAIT of a stack read
        stack_data = 16'h7777;
        MEMREAD    = 1'b1;
        addr       = 12'h900;
        @(negedge clk);
        MEMREAD = 1'b0;
        chk("rst_txn_strobe", {31'd0, rd_stack}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_rd_addr", {20'd0, rd_addr}, 32'd0);
        chk("midrst_sel", {30'd0, sel}, 32'd0);
        chk("midrst_strobes", {29'd0, rd_instr, rd_mmr, rd_stack}, 32'd0);
        chk("midrst_data_out", {16'd0, data_out}, 32'd0);
        chk("midrst_dv", {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_dv", {31'd0, data_valid}, 32'd0);
            chk("midrst_data_zero", {16'd0, data_out}, 32'd0);
        end

        // MMR read after reset with non-selected buses driven to 0xDEAD
        instr_data = 16'hDEAD;
        stack_data = 16'hDEAD;
        mmr_data   = 16'h00A5;
        rd_txn(12'h401, 2'd1, 16'h00A5, 1, 1'b0, 12'h000);
        mmr_data = 16'h005A;
        rd_txn(12'h420, 2'd1, 16'h005A, 1, 1'b0, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
